pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised elastic pipeline register; successor to the fixed-width ID/EX latch.
//  Carries a control field and a data payload between two pipeline stages.
//  - Uses a valid/ready handshake on both sides.
//  - Has a 2-entry skid buffer, so a downstream stall never loses an in-flight instruction.
//  - Flush invalidates all held entries and forces every control bit to zero.
//  Used for ID/EX, EX/MEM and MEM/WB once the core moves to stall-capable pipelining.
// PARAMETERS
//  CTRL_W   4   control bits (regwrite,memtoreg,memread,memwrite); zeroed on flush/bubble
//  DATA_W   92  payload bits (aluop,alusrc1/2,regsrc*,regdst,memdata,epc); never zeroed
//  SKID     1   1 = 2-entry skid buffer; 0 = single register, in_ready = !valid | out_ready
// PORTS
//  CLK        in   1       clock, rising edge
//  RST        in   1       synchronous reset, active-high
//  flush_i    in   1       discard all entries and the input offered this cycle
//  in_valid   in   1       upstream offers in_ctrl/in_data
//  in_ready   out  1       stage can accept; transfer when in_valid & in_ready
//  in_ctrl    in   CTRL_W  control field
//  in_data    in   DATA_W  payload
//  out_valid  out  1       head entry valid
//  out_ready  in   1       downstream accepts; transfer when out_valid & out_ready
//  out_ctrl   out  CTRL_W  head ctrl AND {CTRL_W{out_valid}}
//  out_data   out  DATA_W  head payload; value is don't-care when out_valid=0
//  occupancy  out  2       number of held entries, 0..2 (0..1 when SKID=0)
// BEHAVIOUR
//  - Clock and reset
//    - One clock domain. Reset is synchronous and active-high; it is sampled on the CLK rising edge.
//    - RST: occupancy=0, out_valid=0, out_ctrl=0, in_ready=1 on the following edge.
//    - Payload registers are not reset.
//  - Storage and ordering (SKID=1)
//    - Two entries: head (drives the outputs) and skid. FIFO order is preserved.
//    - States are EMPTY (occ 0), ONE (occ 1) and FULL (occ 2).
//    - in_ready is a registered signal equal to (occupancy != 2). It never depends combinationally on out_ready.
//  - Per-edge update, with push = in_valid&in_ready and pop = out_valid&out_ready
//    - EMPTY + push          -> ONE; head = input.
//    - ONE + push & !pop     -> FULL; skid = input.
//    - ONE + push & pop      -> ONE; head = input.
//    - ONE + pop only        -> EMPTY.
//    - FULL + pop            -> ONE; head = skid. No push is possible because in_ready=0.
//    - Any other combination: hold state and contents.
//  - Latency: 1 cycle from accepted input to out_valid when empty. Throughput is 1/cycle while out_ready=1.
//  - SKID=0
//    - Single entry; in_ready = !out_valid | out_ready (combinational).
//    - Same ctrl gating and flush rules as SKID=1.
//  - Flush
//    - flush_i has priority over push and pop.
//    - Next edge: occupancy=0 and out_valid=0.
//    - The input offered that cycle is dropped, even if in_ready=1.
//    - out_ctrl reads 0 from the cycle after flush.
//  - Priority: RST > flush_i > push/pop.
//  - Bubbles: whenever out_valid=0, out_ctrl=0, so no spurious regwrite/memwrite reaches the next stage.
//  - Upstream contract: in_ctrl/in_data must be held stable while in_valid=1 and in_ready=0. Not checked.
//  - Ordering and widths
//    - No reordering and no duplication.
//    - Every accepted entry leaves exactly once unless it is flushed.
//    - Widths are pass-through; there is no arithmetic on the payload.
// TESTING
//  - Reset: assert RST 2 cycles with in_valid=1 -> occupancy=0, out_valid=0, out_ctrl=0, in_ready=1.
//  - Streaming: out_ready=1; push ctrl=4'b1001 with data=1,2,3 on consecutive cycles.
//    -> out_data is 1,2,3 one cycle later each, back-to-back, with out_ctrl=4'b1001.
//  - Backpressure: out_ready=0; push A,B.
//    -> occupancy=2 and in_ready=0. Offer C, which is held, not accepted.
//    -> Raise out_ready: output order A, B, C with no loss.
//  - Flush in FULL with in_valid=1 offering D: flush_i=1 for one cycle.
//    -> occupancy=0, out_ctrl=0, D never appears on the output.
//  - Simultaneous push and pop in ONE: head=A, push B, out_ready=1 -> next cycle head=B, occupancy=1.
//  - SKID=0 build: repeat streaming and backpressure.
//    -> occupancy never exceeds 1, and in_ready follows out_ready combinationally when the entry is full.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with valid/ready on both sides and an optional 2-entry skid buffer.
// Control bits are gated to zero whenever the head is invalid, so bubbles and flushes never leak writes.
module pipe_stage_skid #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 92,
    parameter int SKID   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic [1:0]        r_occ;
    logic [CTRL_W-1:0] r_head_ctrl;
    logic [DATA_W-1:0] r_head_data;
    logic              w_push;
    logic              w_pop;

    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign out_valid = (r_occ != 2'd0);
    assign out_ctrl  = r_head_ctrl & {CTRL_W{out_valid}};
    assign out_data  = r_head_data;
    assign occupancy = r_occ;

    generate
        if (SKID != 0) begin : g_skid
            logic              r_in_ready;
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic [DATA_W-1:0] r_skid_data;

            // in_ready is registered so it never depends on out_ready in the same cycle.
            assign in_ready = r_in_ready;

            always_ff @(posedge CLK) begin
                if (RST || flush_i) begin
                    r_occ      <= 2'd0;
                    r_in_ready <= 1'b1;
                end else begin
                    case (r_occ)
                        2'd0: begin
                            if (w_push) begin
                                r_occ <= 2'd1;
                            end
                        end
                        2'd1: begin
                            if (w_push && !w_pop) begin
                                r_occ      <= 2'd2;
                                r_in_ready <= 1'b0;
                            end else if (!w_push && w_pop) begin
                                r_occ <= 2'd0;
                            end
                        end
                        2'd2: begin
                            if (w_pop) begin
                                r_occ      <= 2'd1;
                                r_in_ready <= 1'b1;
                            end
                        end
                        default: begin
                            r_occ      <= 2'd0;
                            r_in_ready <= 1'b1;
                        end
                    endcase
                end
            end

            always_ff @(posedge CLK) begin
                if (!RST && !flush_i) begin
                    case (r_occ)
                        2'd0: begin
                            if (w_push) begin
                                r_head_ctrl <= in_ctrl;
                                r_head_data <= in_data;
                            end
                        end
                        2'd1: begin
                            if (w_push && w_pop) begin
                                r_head_ctrl <= in_ctrl;
                                r_head_data <= in_data;
                            end else if (w_push) begin
                                r_skid_ctrl <= in_ctrl;
                                r_skid_data <= in_data;
                            end
                        end
                        2'd2: begin
                            if (w_pop) begin
                                r_head_ctrl <= r_skid_ctrl;
                                r_head_data <= r_skid_data;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end else begin : g_single
            assign in_ready = !out_valid | out_ready;

            always_ff @(posedge CLK) begin
                if (RST || flush_i) begin
                    r_occ <= 2'd0;
                end else if (w_push) begin
                    r_occ <= 2'd1;
                end else if (w_pop) begin
                    r_occ <= 2'd0;
                end
            end

            always_ff @(posedge CLK) begin
                if (!RST && !flush_i && w_push) begin
                    r_head_ctrl <= in_ctrl;
                    r_head_data <= in_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a SKID=1 and a SKID=0 instance fed the same item stream,
// each checked against a queue model of the stage (accepted entries leave in order).
module tb_pipe_stage_skid;
    localparam int CW     = 4;
    localparam int DW     = 92;
    localparam int NL     = 2;
    localparam int STIM_N = 700;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic flush;
    logic out_ready;
    logic rst_offer;
    logic end_req;
    logic end_done = 1'b0;
    logic armed = 1'b0;

    logic          in_valid  [NL];
    logic          in_ready  [NL];
    logic          out_valid [NL];
    logic [CW-1:0] in_ctrl   [NL];
    logic [CW-1:0] out_ctrl  [NL];
    logic [DW-1:0] in_data   [NL];
    logic [DW-1:0] out_data  [NL];
    logic [1:0]    occupancy [NL];

    ent_t stim [STIM_N];
    int   src_lim;
    int   src_idx [NL] = '{0, 0};
    ent_t exp_q [NL][$];

    int checks = 0;
    int errors = 0;

    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_lane
            pipe_stage_skid #(
                .CTRL_W(CW),
                .DATA_W(DW),
                .SKID  ((gi == 0) ? 1 : 0)
            ) u_dut (
                .CLK      (clk),
                .RST      (rst),
                .flush_i  (flush),
                .in_valid (in_valid[gi]),
                .in_ready (in_ready[gi]),
                .in_ctrl  (in_ctrl[gi]),
                .in_data  (in_data[gi]),
                .out_valid(out_valid[gi]),
                .out_ready(out_ready),
                .out_ctrl (out_ctrl[gi]),
                .out_data (out_data[gi]),
                .occupancy(occupancy[gi])
            );
        end
    endgenerate

    task automatic chk(input int l, input string name, input logic [95:0] act, input logic [95:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL lane%0d %s: got %h expected %h at %0t", l, name, act, expv, $time);
        end
    endtask

    // Observes each lane mid-cycle: compares against the model, then applies the
    // coming edge's accept/transfer to the model.
    always @(negedge clk) begin : monitor
        int   sz;
        logic exp_ir;
        logic do_pop;
        logic do_push;
        ent_t h;
        for (int l = 0; l < NL; l++) begin
            sz     = exp_q[l].size();
            exp_ir = (l == 0) ? (sz != 2) : ((sz == 0) || out_ready);
            if (armed) begin
                h = (sz != 0) ? exp_q[l][0] : '0;
                chk(l, "occupancy", 96'(occupancy[l]), 96'(sz));
                chk(l, "out_valid", 96'(out_valid[l]), 96'(sz != 0));
                chk(l, "in_ready",  96'(in_ready[l]),  96'(exp_ir));
                chk(l, "out_ctrl",  96'(out_ctrl[l]),  96'(h.c));
                if (sz != 0)
                    chk(l, "out_data", 96'(out_data[l]), 96'(h.d));
            end
            if (rst) begin
                exp_q[l].delete();
            end else if (flush) begin
                if (in_valid[l])
                    src_idx[l]++;
                exp_q[l].delete();
            end else begin
                do_pop  = (sz != 0) && out_ready;
                do_push = in_valid[l] && exp_ir;
                if (do_pop) begin
                    $display("lane%0d out ctrl=%h data=%h", l, exp_q[l][0].c, exp_q[l][0].d);
                    void'(exp_q[l].pop_front());
                end
                if (do_push) begin
                    exp_q[l].push_back({in_ctrl[l], in_data[l]});
                    src_idx[l]++;
                end
            end
        end
        if (rst)
            armed = 1'b1;
        if (end_req && !end_done) begin
            for (int l = 0; l < NL; l++)
                chk(l, "drained", 96'((src_lim - src_idx[l]) + exp_q[l].size()), 96'(0));
            end_done = 1'b1;
        end
    end

    // Presents the next unconsumed item of the stream to each lane, holding it until taken.
    initial begin : driver
        for (int l = 0; l < NL; l++) begin
            in_valid[l] = 1'b1;
            in_ctrl[l]  = '1;
            in_data[l]  = '1;
        end
        forever begin
            @(posedge clk);
            #2;
            for (int l = 0; l < NL; l++) begin
                if (rst_offer) begin
                    in_valid[l] = 1'b1;
                    in_ctrl[l]  = '1;
                    in_data[l]  = '1;
                end else if (src_idx[l] < src_lim) begin
                    in_valid[l] = 1'b1;
                    in_ctrl[l]  = stim[src_idx[l]].c;
                    in_data[l]  = stim[src_idx[l]].d;
                end else begin
                    in_valid[l] = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [CW-1:0] c, input logic [DW-1:0] d);
        stim[src_lim] = {c, d};
        src_lim++;
    endtask

    function automatic logic drained();
        logic r;
        r = 1'b1;
        for (int l = 0; l < NL; l++)
            if (src_idx[l] != src_lim || exp_q[l].size() != 0)
                r = 1'b0;
        return r;
    endfunction

    initial begin : scenario
        logic [95:0] rnd;
        int          w;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        rst_offer = 1'b1;
        end_req   = 1'b0;
        src_lim   = 0;
        tick(2);
        rst       = 1'b0;
        rst_offer = 1'b0;
        tick(2);

        // Streaming
        out_ready = 1'b1;
        offer(4'b1001, 92'd1);
        offer(4'b1001, 92'd2);
        offer(4'b1001, 92'd3);
        tick(6);

        // Backpressure: A, B fill the stage, C waits
        out_ready = 1'b0;
        offer(4'b0110, 92'hA);
        offer(4'b1100, 92'hB);
        offer(4'b0011, 92'hC);
        tick(4);
        out_ready = 1'b1;
        tick(6);

        // Flush while full with another item on offer
        out_ready = 1'b0;
        offer(4'b1111, 92'hE);
        offer(4'b1010, 92'hF);
        offer(4'b0101, 92'hD);
        tick(3);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(2);
        out_ready = 1'b1;
        tick(5);

        // Push and pop together with one entry held
        out_ready = 1'b0;
        offer(4'b0001, 92'h6);
        tick(2);
        out_ready = 1'b1;
        offer(4'b1000, 92'h7);
        tick(4);

        // Randomised traffic with occasional flush and reset
        for (int cyc = 0; cyc < 1500; cyc++) begin
            out_ready = ($urandom_range(0, 99) < 65);
            flush     = ($urandom_range(0, 99) < 2);
            rst       = ($urandom_range(0, 299) == 0);
            if (src_lim < STIM_N && (src_lim - src_idx[0]) < 3 && (src_lim - src_idx[1]) < 3
                && $urandom_range(0, 99) < 70) begin
                rnd = {$urandom(), $urandom(), $urandom()};
                offer(CW'($urandom()), rnd[DW-1:0]);
            end
            tick(1);
        end

        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        w = 0;
        while (w < 300 && !drained()) begin
            tick(1);
            w++;
        end
        end_req = 1'b1;
        tick(2);
        if (!end_done) begin
            errors++;
            $display("FAIL end_check: got not done expected done");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
